rams_sdp_be_rst: RTL and testbench

- Simple-dual-port block RAM: one write port, one independent read port, on a single clock.
- Generalises the single-port resettable-output RAM with:
  - per-byte write enables
  - selectable read latency (1 or 2)
  - selectable read-during-write collision mode
  - a read-valid flag
- Used for caches, register-file shadows and I/O buffers in the core where a read and a write must issue in the same cycle.

---
 rtl/rams_sdp_be_rst_pkg.sv | 29 ++
 rtl/rams_sdp_be_rst_if.sv | 29 ++
 rtl/rams_sdp_be_rst_out_pipe.sv | 31 +++
 rtl/rams_sdp_be_rst.sv | 97 +++++++++
 tb/tb_rams_sdp_be_rst.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/rams_sdp_be_rst_pkg.sv
// Shared constants and helpers for the simple-dual-port byte-enable RAM.
// byte_merge is shared by the write path and the write-first read bypass.
`timescale 1ns/1ps
package ram_pkg;

  localparam int RAM_READ_FIRST  = 0;
  localparam int RAM_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int RAM_MAX_WIDTH = 256;
  typedef logic [RAM_MAX_WIDTH-1:0] ram_word_t;

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Lane i of the result is new_word when be[i] is set, else old_word.
  function automatic ram_word_t byte_merge(input ram_word_t old_word,
                                           input ram_word_t new_word,
                                           input ram_word_t be,
                                           input int        byte_width);
    ram_word_t merged;
    for (int i = 0; i < RAM_MAX_WIDTH; i++) begin
      merged[i] = be[i / byte_width] ? new_word[i] : old_word[i];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rams_sdp_be_rst_if.sv
// Write/read bus of the simple-dual-port RAM; master drives requests,
// slave (the RAM) returns read data and the read-valid pulse.
`timescale 1ns/1ps
interface rams_sdp_be_rst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int NUM_LANES = ram_pkg::num_lanes(DATA_WIDTH, BYTE_WIDTH);

  logic                  wr_en;
  logic [NUM_LANES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/rams_sdp_be_rst_out_pipe.sv
// Optional output register stage: data advances only with a valid read so
// o_data holds between reads; both registers clear asynchronously on rst.
`timescale 1ns/1ps
module rams_out_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/rams_sdp_be_rst.sv
// Simple-dual-port block RAM with byte enables, 1- or 2-cycle read latency,
// read-first / write-first collision handling and a read-valid pulse.
`timescale 1ns/1ps
module rams_sdp_be_rst
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_DEPTH   = 1024,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = RAM_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  rams_sdp_be_rst_if.slave  bus
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_WIDTH > RAM_MAX_WIDTH) begin : g_chk_max
    $error("DATA_WIDTH exceeds RAM_MAX_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_depth
    $error("DATA_DEPTH exceeds 2**ADDR_WIDTH");
  end
  if (WRITE_MODE != RAM_READ_FIRST && WRITE_MODE != RAM_WRITE_FIRST) begin : g_chk_mode
    $error("WRITE_MODE must be 0 or 1");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DATA_DEPTH);

  // NOTE: the array has no reset so it maps onto block RAM; the declaration
  // initialiser provides the configuration-time zero contents instead.
  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH] = '{default: '0};

  logic                  w_wr_hit;
  logic                  w_rd_in_range;
  logic                  w_collide;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  assign w_wr_hit      = bus.wr_en && !rst && ({1'b0, bus.wr_addr} < DEPTH_LIMIT);
  assign w_rd_in_range = {1'b0, bus.rd_addr} < DEPTH_LIMIT;
  assign w_collide     = w_wr_hit && (bus.wr_addr == bus.rd_addr);
  assign w_wr_merged   = DATA_WIDTH'(byte_merge(ram_word_t'(r_mem[bus.wr_addr]),
                                                ram_word_t'(bus.wr_data),
                                                ram_word_t'(bus.wr_be),
                                                BYTE_WIDTH));

  always_ff @(posedge clk) begin
    if (w_wr_hit) r_mem[bus.wr_addr] <= w_wr_merged;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[bus.rd_addr];
      // Write-first bypass; on a collision the merged write word is exactly the new read word.
      if (WRITE_MODE == RAM_WRITE_FIRST && w_collide) w_rd_word = w_wr_merged;
    end
  end

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_pipe
    rams_out_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_out_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_data  (r_rd_data),
      .i_valid (r_rd_valid),
      .o_data  (bus.rd_data),
      .o_valid (bus.rd_valid)
    );
  end else begin : g_direct
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
  end

endmodule

// File: tb/tb_rams_sdp_be_rst.sv
// Directed bench: dut_a is latency-1 read-first, dut_b latency-2 write-first,
// both 1000 words deep and driven by identical stimulus.
`timescale 1ns/1ps
module tb_rams_sdp_be_rst;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [3:0]  wr_be;
  logic [9:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rams_sdp_be_rst_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) if_a ();
  rams_sdp_be_rst_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10)) if_b ();

  assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;
  assign if_a.wr_be = wr_be;     assign if_b.wr_be = wr_be;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
  assign if_a.rd_en = rd_en;     assign if_b.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr;

  rams_sdp_be_rst #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DATA_DEPTH(1000),
                    .READ_LATENCY(1), .WRITE_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));

  rams_sdp_be_rst #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .DATA_DEPTH(1000),
                    .READ_LATENCY(2), .WRITE_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    cycle();
    wr_en = 1'b0;
  endtask

  // Single isolated read: A completes after one edge, B after two.
  task automatic expect_read(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = addr;
    cycle();
    rd_en = 1'b0;
    n_cmp++; if (if_a.rd_data !== exp) begin n_err++; $display("FAIL %s A data: got %h want %h", tag, if_a.rd_data, exp); end
    n_cmp++; if (if_a.rd_valid !== 1'b1) begin n_err++; $display("FAIL %s A valid: got %b want 1", tag, if_a.rd_valid); end
    n_cmp++; if (if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL %s B early valid: got %b want 0", tag, if_b.rd_valid); end
    cycle();
    n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_err++; $display("FAIL %s A valid drop: got %b want 0", tag, if_a.rd_valid); end
    n_cmp++; if (if_a.rd_data !== exp) begin n_err++; $display("FAIL %s A data hold: got %h want %h", tag, if_a.rd_data, exp); end
    n_cmp++; if (if_b.rd_data !== exp) begin n_err++; $display("FAIL %s B data: got %h want %h", tag, if_b.rd_data, exp); end
    n_cmp++; if (if_b.rd_valid !== 1'b1) begin n_err++; $display("FAIL %s B valid: got %b want 1", tag, if_b.rd_valid); end
    cycle();
    n_cmp++; if (if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL %s B valid drop: got %b want 0", tag, if_b.rd_valid); end
    n_cmp++; if (if_b.rd_data !== exp) begin n_err++; $display("FAIL %s B data hold: got %h want %h", tag, if_b.rd_data, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) cycle();
    n_cmp++; if (if_a.rd_data !== 32'h0 || if_a.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset A: got %h/%b want 0/0", if_a.rd_data, if_a.rd_valid); end
    n_cmp++; if (if_b.rd_data !== 32'h0 || if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset B: got %h/%b want 0/0", if_b.rd_data, if_b.rd_valid); end
    rst = 1'b0;
    write_word(10'd20, 32'hDEADBEEF, 4'hF);
    rd_en = 1'b1; rd_addr = 10'd20;
    cycle();
    rd_en = 1'b0;
    n_cmp++; if (if_a.rd_data !== 32'hDEADBEEF || if_a.rd_valid !== 1'b1) begin n_err++; $display("FAIL preload A: got %h/%b want deadbeef/1", if_a.rd_data, if_a.rd_valid); end
    cycle();
    n_cmp++; if (if_b.rd_data !== 32'hDEADBEEF || if_b.rd_valid !== 1'b1) begin n_err++; $display("FAIL preload B: got %h/%b want deadbeef/1", if_b.rd_data, if_b.rd_valid); end
    // Assert reset mid-cycle; outputs must clear before the next edge.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (if_a.rd_data !== 32'h0) begin n_err++; $display("FAIL async rst A data: got %h want 0", if_a.rd_data); end
    n_cmp++; if (if_b.rd_data !== 32'h0 || if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL async rst B: got %h/%b want 0/0", if_b.rd_data, if_b.rd_valid); end
    cycle();
    rst = 1'b0;
    expect_read(10'd5, 32'h0, "rst_read5");
  endtask

  task automatic test_byte_enables();
    write_word(10'd3, 32'h11223344, 4'b1111);
    write_word(10'd3, 32'hAABBCCDD, 4'b0101);
    write_word(10'd3, 32'hFFFFFFFF, 4'b0000);
    expect_read(10'd3, 32'h11BB33DD, "byte_en");
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 32'hCAFEF00D; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 10'd7;
    cycle();
    wr_en = 1'b0;
    n_cmp++; if (if_a.rd_data !== 32'h0 || if_a.rd_valid !== 1'b1) begin n_err++; $display("FAIL coll read_first: got %h/%b want 00000000/1", if_a.rd_data, if_a.rd_valid); end
    cycle();
    rd_en = 1'b0;
    n_cmp++; if (if_a.rd_data !== 32'h0000F00D || if_a.rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b A: got %h/%b want 0000f00d/1", if_a.rd_data, if_a.rd_valid); end
    n_cmp++; if (if_b.rd_data !== 32'h0000F00D || if_b.rd_valid !== 1'b1) begin n_err++; $display("FAIL coll write_first: got %h/%b want 0000f00d/1", if_b.rd_data, if_b.rd_valid); end
    cycle();
    n_cmp++; if (if_a.rd_valid !== 1'b0) begin n_err++; $display("FAIL coll A valid drop: got %b want 0", if_a.rd_valid); end
    n_cmp++; if (if_b.rd_data !== 32'h0000F00D || if_b.rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b B: got %h/%b want 0000f00d/1", if_b.rd_data, if_b.rd_valid); end
    cycle();
    n_cmp++; if (if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL coll B valid drop: got %b want 0", if_b.rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b;
    logic        vld_a, vld_b;
    for (int k = 0; k < 4; k++) write_word(10'(k), 32'hA0 + 32'(k), 4'hF);
    for (int c = 0; c < 6; c++) begin
      rd_en = (c < 4); rd_addr = 10'((c < 4) ? c : 0);
      cycle();
      vld_a = (c < 4);
      exp_a = 32'hA0 + 32'((c < 3) ? c : 3);
      vld_b = (c >= 1 && c <= 4);
      exp_b = 32'hA0 + 32'((c < 4) ? c - 1 : 3);
      n_cmp++; if (if_a.rd_valid !== vld_a || if_a.rd_data !== exp_a) begin n_err++; $display("FAIL stream A c=%0d: got %h/%b want %h/%b", c, if_a.rd_data, if_a.rd_valid, exp_a, vld_a); end
      n_cmp++; if (if_b.rd_valid !== vld_b) begin n_err++; $display("FAIL stream B valid c=%0d: got %b want %b", c, if_b.rd_valid, vld_b); end
      if (c >= 1) begin
        n_cmp++; if (if_b.rd_data !== exp_b) begin n_err++; $display("FAIL stream B data c=%0d: got %h want %h", c, if_b.rd_data, exp_b); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_pipeline();
    rd_en = 1'b1; rd_addr = 10'd2;
    cycle();
    rd_en = 1'b0;
    rst = 1'b1;
    // This write lands while reset is held and must be dropped.
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 32'h0; wr_be = 4'hF;
    #1;
    n_cmp++; if (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 32'h0) begin n_err++; $display("FAIL midpipe rst B: got %h/%b want 0/0", if_b.rd_data, if_b.rd_valid); end
    cycle();
    rst = 1'b0; wr_en = 1'b0;
    n_cmp++; if (if_b.rd_valid !== 1'b0 || if_a.rd_valid !== 1'b0) begin n_err++; $display("FAIL midpipe valid1: got A=%b B=%b want 0/0", if_a.rd_valid, if_b.rd_valid); end
    cycle();
    n_cmp++; if (if_b.rd_valid !== 1'b0) begin n_err++; $display("FAIL midpipe ghost pulse: got %b want 0", if_b.rd_valid); end
    expect_read(10'd2, 32'hA2, "midpipe_reread");
  endtask

  task automatic test_boundaries();
    write_word(10'd999, 32'h12345678, 4'hF);
    expect_read(10'd999, 32'h12345678, "addr999");
    write_word(10'd1000, 32'hFFFFFFFF, 4'hF);
    expect_read(10'd1000, 32'h0, "addr1000");
    expect_read(10'd999, 32'h12345678, "addr999_after");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_enables();
    test_collision();
    test_back_to_back();
    test_reset_mid_pipeline();
    test_boundaries();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
